online_hd_otfc_rx: RTL and testbench

- Receiving end of the hybrid-digit online product stream produced by Multiplier_hd.
- Consumes MSD-first 2-bit signed digits over a valid/ready handshake.
- Uses on-the-fly conversion (Q/QM registers), so no carry-propagate add is needed.
- After NDIG digits, presents one (NDIG+1)-bit two's-complement fraction on a valid/ready output.

---
 rtl/online_hd_pkg.sv | 26 ++
 rtl/hd_otfc_step.sv | 29 ++
 rtl/online_hd_otfc_rx.sv | 125 ++++++++++++
 tb/tb_online_hd_otfc_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/online_hd_pkg.sv
// Shared digit encodings, FSM state type and digit decode for the hybrid-digit
// on-the-fly-conversion receiver.
package online_hd_pkg;

  localparam logic [1:0] HD_ZERO = 2'b00;
  localparam logic [1:0] HD_POS  = 2'b10;
  localparam logic [1:0] HD_NEG  = 2'b01;
  localparam logic [1:0] HD_ILL  = 2'b11;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // 2'b11 has both plus and minus set, so it nets to zero.
  function automatic logic signed [1:0] hd_value(input logic [1:0] din);
    logic signed [1:0] v;
    case (din)
      HD_POS:  v = 2'sd1;
      HD_NEG:  v = -2'sd1;
      default: v = 2'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/hd_otfc_step.sv
// One on-the-fly conversion step: appends a signed digit to Q (value) and QM
// (value - 1 ulp) without any carry-propagate addition.
module hd_otfc_step #(
  parameter int W = 21
) (
  input  logic signed [W-1:0] q,
  input  logic signed [W-1:0] qm,
  input  logic        [1:0]   digit,
  output logic signed [W-1:0] q_nxt,
  output logic signed [W-1:0] qm_nxt
);
  import online_hd_pkg::*;

  logic signed [1:0] dv;

  always_comb begin
    dv     = hd_value(digit);
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    if (dv == 2'sd1) begin
      q_nxt  = {q[W-2:0], 1'b1};
      qm_nxt = {q[W-2:0], 1'b0};
    end else if (dv == -2'sd1) begin
      q_nxt  = {qm[W-2:0], 1'b1};
      qm_nxt = {qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/online_hd_otfc_rx.sv
// Receives MSD-first hybrid digits and presents each NDIG-digit word as an
// (NDIG+1)-bit two's-complement fraction. Define ONLINE_HD_DIGIT_ERR_EN to add
// a sticky digit_err flag for the 2'b11 code.
module online_hd_otfc_rx #(
  parameter int NDIG = 20,
  parameter int CW   = 5
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic [1:0]         din,
  input  logic               din_vld,
  output logic               din_rdy,
  output logic signed [NDIG:0] dout,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic [CW-1:0]      word_cnt
`ifdef ONLINE_HD_DIGIT_ERR_EN
  ,
  output logic               digit_err
`endif
);
  import online_hd_pkg::*;

  localparam int W = NDIG + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e              state_q, state_d;
  logic signed [W-1:0] q_q, q_d, qm_q, qm_d;
  logic signed [W-1:0] q_step, qm_step;
  logic signed [W-1:0] dout_q, dout_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dout_vld_q, dout_vld_d;
  logic                din_rdy_q, din_rdy_d;
  logic                accept;

  hd_otfc_step #(.W(W)) u_step (
    .q      (q_q),
    .qm     (qm_q),
    .digit  (din),
    .q_nxt  (q_step),
    .qm_nxt (qm_step)
  );

  assign accept = din_vld && din_rdy_q;

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    qm_d       = qm_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    din_rdy_d  = din_rdy_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          q_d   = q_step;
          qm_d  = qm_step;
          cnt_d = cnt_q + CW'(1);
          // Last digit: the result is the freshly converted Q, registered so
          // dout_vld rises one cycle after the final accept.
          if (cnt_q == LAST) begin
            state_d    = HOLD;
            dout_d     = q_step;
            dout_vld_d = 1'b1;
            din_rdy_d  = 1'b0;
          end
        end
      end
      HOLD: begin
        if (dout_vld_q && dout_rdy) begin
          state_d    = ACC;
          q_d        = '0;
          qm_d       = '1;
          cnt_d      = '0;
          dout_vld_d = 1'b0;
          din_rdy_d  = 1'b1;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q    <= ACC;
      q_q        <= '0;
      qm_q       <= '1;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      din_rdy_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      qm_q       <= qm_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      din_rdy_q  <= din_rdy_d;
    end
  end

`ifdef ONLINE_HD_DIGIT_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept && (din == HD_ILL)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign digit_err = err_q;
`endif

  assign din_rdy  = din_rdy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_online_hd_otfc_rx.sv
// Directed bench for online_hd_otfc_rx at NDIG=4, CW=3 with hand-computed
// results; inputs change and outputs are sampled on the falling edge.
module tb_online_hd_otfc_rx;

  localparam int NDIG = 4;
  localparam int CW   = 3;

  logic              clk = 1'b0;
  logic              asyn_reset;
  logic [1:0]        din;
  logic              din_vld;
  logic              din_rdy;
  logic [NDIG:0]     dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic [CW-1:0]     word_cnt;
`ifdef ONLINE_HD_DIGIT_ERR_EN
  logic              digit_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  online_hd_otfc_rx #(.NDIG(NDIG), .CW(CW)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .din        (din),
    .din_vld    (din_vld),
    .din_rdy    (din_rdy),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .word_cnt   (word_cnt)
`ifdef ONLINE_HD_DIGIT_ERR_EN
    ,
    .digit_err  (digit_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives four digits (MSD in w[7:6]) back to back; returns on the falling
  // edge right after the last accept, with din_vld dropped.
  task automatic send_word(input logic [7:0] w);
    int guard;
    for (int i = 0; i < 4; i++) begin
      din     = w[7-2*i -: 2];
      din_vld = 1'b1;
      guard   = 0;
      while (!din_rdy && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!din_rdy) check("rdy_timeout", 32'(din_rdy), 32'd1);
      @(negedge clk);
    end
    din_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    asyn_reset = 1'b1;
    din        = 2'b00;
    din_vld    = 1'b0;
    dout_rdy   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_din_rdy",  32'(din_rdy),  32'd1);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_dout",     32'(dout),     32'd0);
    asyn_reset = 1'b0;
    @(negedge clk);

    // +1,0,-1,+1 -> 7/16
    send_word(8'b10_00_01_10);
    check("w1_vld",  32'(dout_vld), 32'd1);
    check("w1_dout", 32'(dout),     32'h07);
    check("w1_rdy",  32'(din_rdy),  32'd0);
    @(negedge clk);
    check("w1_vld_drop", 32'(dout_vld), 32'd0);
    check("w1_rdy_back", 32'(din_rdy),  32'd1);
    check("w1_cnt_clr",  32'(word_cnt), 32'd0);

    // -1,-1,-1,-1 -> -15/16, then +1,-1,-1,-1 -> 1/16
    send_word(8'b01_01_01_01);
    check("w2_vld",  32'(dout_vld), 32'd1);
    check("w2_dout", 32'(dout),     32'h11);
    check("w2_bubble", 32'(din_rdy), 32'd0);
    @(negedge clk);
    check("w2_rdy_after_bubble", 32'(din_rdy), 32'd1);
    send_word(8'b10_01_01_01);
    check("w3_dout", 32'(dout), 32'h01);
    check("w3_vld",  32'(dout_vld), 32'd1);
    @(negedge clk);

    // zeros with both encodings
`ifdef ONLINE_HD_DIGIT_ERR_EN
    check("err_before", 32'(digit_err), 32'd0);
`endif
    send_word(8'b00_11_00_11);
    check("w4_dout", 32'(dout), 32'h00);
    check("w4_vld",  32'(dout_vld), 32'd1);
`ifdef ONLINE_HD_DIGIT_ERR_EN
    check("err_sticky", 32'(digit_err), 32'd1);
`endif
    @(negedge clk);

    // +1,+1,0,0 -> 12/16 under backpressure, with digits offered during HOLD
    dout_rdy = 1'b0;
    send_word(8'b10_10_00_00);
    din     = 2'b10;
    din_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_vld",  32'(dout_vld), 32'd1);
      check("bp_dout", 32'(dout),     32'h0C);
      check("bp_rdy",  32'(din_rdy),  32'd0);
      check("bp_cnt",  32'(word_cnt), 32'd4);
      @(negedge clk);
    end
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_vld", 32'(dout_vld), 32'd0);
    check("bp_release_rdy", 32'(din_rdy),  32'd1);
    check("bp_release_cnt", 32'(word_cnt), 32'd0);

    // partial word discarded by reset
    din     = 2'b10;
    din_vld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    din_vld = 1'b0;
    check("partial_cnt", 32'(word_cnt), 32'd2);
    asyn_reset = 1'b1;
    @(negedge clk);
    asyn_reset = 1'b0;
    check("mid_rst_cnt", 32'(word_cnt), 32'd0);
    check("mid_rst_rdy", 32'(din_rdy),  32'd1);
    check("mid_rst_vld", 32'(dout_vld), 32'd0);
`ifdef ONLINE_HD_DIGIT_ERR_EN
    check("err_cleared", 32'(digit_err), 32'd0);
`endif
    send_word(8'b00_00_00_10);
    check("w6_dout", 32'(dout), 32'h01);
    check("w6_vld",  32'(dout_vld), 32'd1);
    @(negedge clk);

    // din_vld toggling: +1 x4 -> 15/16
    din = 2'b10;
    for (int i = 0; i < 4; i++) begin
      din_vld = 1'b1;
      @(negedge clk);
      if (i < 3) begin
        check("tog_cnt_vld", 32'(word_cnt), 32'(i + 1));
        din_vld = 1'b0;
        @(negedge clk);
        check("tog_cnt_idle", 32'(word_cnt), 32'(i + 1));
      end
    end
    din_vld = 1'b0;
    check("w7_vld",  32'(dout_vld), 32'd1);
    check("w7_dout", 32'(dout),     32'h0F);
    @(negedge clk);
    check("w7_vld_drop", 32'(dout_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
